// File: rtl/branch_target_predictor_pkg.sv
// Shared types and constants for the branch target predictor.
// Entry layout and direction-counter encodings.
package branch_target_predictor_pkg;

  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [1:0]        ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] ctr,
    input logic       taken
  );
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != CTR_ST) nxt = ctr + 2'd1;
    if (!taken && ctr != CTR_SNT) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_target_predictor_storage.sv
// BTB entry array: two combinational read ports
// (fetch lookup, training lookup) and one synchronous write port.
module btb_storage
  import branch_target_predictor_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] fetch_idx,
  output btb_entry_t            fetch_entry,
  input  logic [INDEX_BITS-1:0] train_idx,
  output btb_entry_t            train_entry,
  input  logic                  wr_en,
  input  btb_entry_t            wr_entry
);

  localparam int DEPTH = 1 << INDEX_BITS;

  btb_entry_t mem [DEPTH];

  assign fetch_entry = mem[fetch_idx];
  assign train_entry = mem[train_idx];

  // Reset invalidates every entry; otherwise write the trained entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{valid: 1'b0, tag: '0,
                    target: '0, ctr: CTR_WNT};
      end
    end else if (wr_en) begin
      mem[train_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters, decode-stage
// prediction register and hit/mispredict statistics.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_pred_valid,
  output logic                  if_pred_taken,
  output logic [ADDR_WIDTH-1:0] if_pred_target,
  input  logic                  dec_stall,
  input  logic                  dec_flush,
  output logic                  dec_pred_valid,
  output logic                  dec_pred_taken,
  output logic [ADDR_WIDTH-1:0] dec_pred_target,
  input  logic                  res_valid,
  input  logic [ADDR_WIDTH-1:0] res_pc,
  input  logic                  res_is_branch,
  input  logic                  res_outcome,
  input  logic [ADDR_WIDTH-1:0] res_target,
  output logic [31:0]           hit_count,
  output logic [31:0]           mispredict_count
);

  logic [INDEX_BITS-1:0] if_idx, res_idx;
  logic [TAG_BITS-1:0]   if_tag, res_tag;
  btb_entry_t            fe, te, wr_entry;
  logic                  wr_en, hit, res_hit, upd;
  logic                  br_hit, br_alloc, alias_clr;
  logic                  pred_t, act_t, mispredict;
  logic                  unused_pc_lsbs;

  assign if_idx  = if_pc[INDEX_BITS+1:2];
  assign if_tag  = if_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign res_idx = res_pc[INDEX_BITS+1:2];
  assign res_tag = res_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign unused_pc_lsbs = ^{if_pc[1:0], res_pc[1:0]};

  btb_storage #(.INDEX_BITS(INDEX_BITS)) u_storage (
    .clk         (clk),
    .rst         (rst),
    .fetch_idx   (if_idx),
    .fetch_entry (fe),
    .train_idx   (res_idx),
    .train_entry (te),
    .wr_en       (wr_en),
    .wr_entry    (wr_entry)
  );

  assign hit     = if_req_valid & fe.valid & (fe.tag == if_tag);
  assign res_hit = te.valid & (te.tag == res_tag);

  assign if_pred_valid  = hit;
  assign if_pred_taken  = hit & fe.ctr[1];
  assign if_pred_target = hit ? fe.target : '0;

  // A stalled decode re-presents its resolution; train only once.
  assign upd       = res_valid & ~dec_stall;
  assign br_hit    = upd & res_is_branch & res_hit;
  assign br_alloc  = upd & res_is_branch & ~res_hit & res_outcome;
  assign alias_clr = upd & ~res_is_branch & res_hit;

  // Build the trained entry for the resolved PC's slot.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = te;
    unique case (1'b1)
      br_hit: begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_next(te.ctr, res_outcome);
        if (res_outcome) wr_entry.target = res_target;
      end
      br_alloc: begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: res_tag,
                     target: res_target, ctr: CTR_WT};
      end
      alias_clr: begin
        wr_en          = 1'b1;
        wr_entry.valid = 1'b0;
      end
      default: ;
    endcase
  end

  // Decode-stage prediction copy: stall holds, flush zeroes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_pred_valid  <= 1'b0;
      dec_pred_taken  <= 1'b0;
      dec_pred_target <= '0;
    end else if (dec_stall) begin
      dec_pred_valid  <= dec_pred_valid;
      dec_pred_taken  <= dec_pred_taken;
      dec_pred_target <= dec_pred_target;
    end else if (dec_flush) begin
      dec_pred_valid  <= 1'b0;
      dec_pred_taken  <= 1'b0;
      dec_pred_target <= '0;
    end else begin
      dec_pred_valid  <= if_pred_valid;
      dec_pred_taken  <= if_pred_taken;
      dec_pred_target <= if_pred_target;
    end
  end

  assign pred_t     = dec_pred_valid & dec_pred_taken;
  assign act_t      = res_is_branch & res_outcome;
  assign mispredict = (pred_t != act_t) |
                      (act_t & (dec_pred_target != res_target));

  // Lookup hits and mispredicted resolutions, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count        <= '0;
      mispredict_count <= '0;
    end else begin
      if (hit && !dec_stall) hit_count <= hit_count + 32'd1;
      if (upd && mispredict) mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor.
// Expected values are hand-derived per cycle.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_pc;
  logic        if_pred_valid, if_pred_taken;
  logic [31:0] if_pred_target;
  logic        dec_stall, dec_flush;
  logic        dec_pred_valid, dec_pred_taken;
  logic [31:0] dec_pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_is_branch, res_outcome;
  logic [31:0] res_target;
  logic [31:0] hit_count, mispredict_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_target_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .if_req_valid     (if_req_valid),
    .if_pc            (if_pc),
    .if_pred_valid    (if_pred_valid),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target),
    .dec_stall        (dec_stall),
    .dec_flush        (dec_flush),
    .dec_pred_valid   (dec_pred_valid),
    .dec_pred_taken   (dec_pred_taken),
    .dec_pred_target  (dec_pred_target),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_is_branch    (res_is_branch),
    .res_outcome      (res_outcome),
    .res_target       (res_target),
    .hit_count        (hit_count),
    .mispredict_count (mispredict_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lookup(input logic v, input logic [31:0] pc);
    if_req_valid = v;
    if_pc        = pc;
  endtask

  task automatic resolve(input logic v, input logic [31:0] pc,
                         input logic br, input logic tk,
                         input logic [31:0] tgt);
    res_valid     = v;
    res_pc        = pc;
    res_is_branch = br;
    res_outcome   = tk;
    res_target    = tgt;
  endtask

  task automatic pred(input string tag, input logic v,
                      input logic t, input logic [31:0] tgt);
    chk({tag, "_valid"}, {31'd0, if_pred_valid}, {31'd0, v});
    chk({tag, "_taken"}, {31'd0, if_pred_taken}, {31'd0, t});
    chk({tag, "_target"}, if_pred_target, tgt);
  endtask

  task automatic stats(input string tag,
                       input logic [31:0] h, input logic [31:0] m);
    chk({tag, "_hits"}, hit_count, h);
    chk({tag, "_misp"}, mispredict_count, m);
  endtask

  task automatic decq(input string tag, input logic v,
                      input logic t, input logic [31:0] tgt);
    chk({tag, "_dvalid"}, {31'd0, dec_pred_valid}, {31'd0, v});
    chk({tag, "_dtaken"}, {31'd0, dec_pred_taken}, {31'd0, t});
    chk({tag, "_dtarget"}, dec_pred_target, tgt);
  endtask

  initial begin
    rst = 1'b1;
    dec_stall = 1'b0;
    dec_flush = 1'b0;
    lookup(1'b0, 32'h0);
    resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // A: cold miss, allocate 0x100 -> 0x200
    lookup(1'b1, 32'h100);
    resolve(1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
    #1;
    pred("A", 1'b0, 1'b0, 32'h0);
    stats("A", 0, 0);
    decq("A", 1'b0, 1'b0, 32'h0);
    tick();

    // B: new entry visible, ctr=10
    resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    pred("B", 1'b1, 1'b1, 32'h200);
    stats("B", 0, 1);
    tick();

    // C: decode copy loaded; first not-taken (10->01)
    #1;
    stats("C", 1, 1);
    decq("C", 1'b1, 1'b1, 32'h200);
    lookup(1'b0, 32'h100);
    resolve(1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    tick();

    // D: second not-taken (01->00)
    lookup(1'b1, 32'h100);
    #1;
    stats("D", 1, 2);
    pred("D", 1'b1, 1'b0, 32'h200);
    tick();

    // E: third not-taken saturates at 00
    #1;
    pred("E", 1'b1, 1'b0, 32'h200);
    stats("E", 2, 2);
    tick();

    // F: floor held; taken 00->01
    resolve(1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
    #1;
    pred("F", 1'b1, 1'b0, 32'h200);
    stats("F", 3, 2);
    tick();

    // G: same-cycle update and lookup, pre-update view
    #1;
    pred("G", 1'b1, 1'b0, 32'h200);
    stats("G", 4, 3);
    tick();

    // H: update now visible (ctr=10)
    resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    pred("H", 1'b1, 1'b1, 32'h200);
    stats("H", 5, 4);
    tick();

    // I: alias 0x200 misses; non-branch resolve leaves entry
    lookup(1'b1, 32'h200);
    resolve(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    #1;
    pred("I", 1'b0, 1'b0, 32'h0);
    decq("I", 1'b1, 1'b1, 32'h200);
    tick();

    // J: 0x100 entry intact
    lookup(1'b1, 32'h100);
    resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    pred("J", 1'b1, 1'b1, 32'h200);
    stats("J", 6, 5);
    tick();

    // K: alias taken -> replace (target mismatch mispredict)
    lookup(1'b1, 32'h200);
    resolve(1'b1, 32'h200, 1'b1, 1'b1, 32'h300);
    #1;
    stats("K", 7, 5);
    tick();

    // L: 0x100 evicted
    lookup(1'b1, 32'h100);
    resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    pred("L", 1'b0, 1'b0, 32'h0);
    stats("L", 7, 6);
    tick();

    // M: 0x200 now resident
    lookup(1'b1, 32'h200);
    #1;
    pred("M", 1'b1, 1'b1, 32'h300);
    tick();

    // N: three stalled cycles with a pending resolution
    for (int i = 0; i < 3; i++) begin
      dec_stall = 1'b1;
      lookup(1'b1, (i == 2) ? 32'h100 : 32'h200);
      resolve(1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
      #1;
      decq("N", 1'b1, 1'b1, 32'h300);
      stats("N", 8, 6);
      if (i < 2) chk("N_ctr_held", {31'd0, if_pred_taken}, 32'd1);
      tick();
    end

    // O: stall released, resolution trains once (10->01)
    dec_stall = 1'b0;
    lookup(1'b1, 32'h200);
    #1;
    decq("O", 1'b1, 1'b1, 32'h300);
    stats("O", 8, 6);
    pred("O", 1'b1, 1'b1, 32'h300);
    tick();

    // P: flush the decode copy
    resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    dec_flush = 1'b1;
    #1;
    stats("P", 9, 7);
    pred("P", 1'b1, 1'b0, 32'h300);
    tick();

    // Q: flushed
    dec_flush = 1'b0;
    lookup(1'b0, 32'h0);
    #1;
    decq("Q", 1'b0, 1'b0, 32'h0);
    stats("Q", 10, 7);
    tick();

    // R: reset with a pending taken resolution
    rst = 1'b1;
    lookup(1'b1, 32'h200);
    resolve(1'b1, 32'h100, 1'b1, 1'b1, 32'h500);
    tick();

    // S: everything cleared, pending update discarded
    rst = 1'b0;
    resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    pred("S200", 1'b0, 1'b0, 32'h0);
    stats("S", 0, 0);
    decq("S", 1'b0, 1'b0, 32'h0);
    lookup(1'b1, 32'h100);
    #1;
    pred("S100", 1'b0, 1'b0, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
